// File: rtl/ra_arb_pkg.sv
// Shared constants and response-register type for the 2R1W register-array arbiter.
package ra_arb_pkg;

  localparam int ADR_W    = 5;
  localparam int DAT_W    = 32;
  localparam int NREQ_MAX = 8;
  localparam int OWN_W    = $clog2(NREQ_MAX);

  typedef struct packed {
    logic             valid;
    logic [OWN_W-1:0] owner;
    logic             fwd;
    logic [DAT_W-1:0] fwd_dat;
  } ra_rsp_t;

  // Advance a requester index by one, wrapping at n.
  function automatic logic [OWN_W-1:0] idx_inc(input logic [OWN_W-1:0] idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/ra_rr_pick.sv
// Round-robin picker: first eligible request at or after ptr, ascending with wrap.
module ra_rr_pick
  import ra_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [OWN_W-1:0] ptr,
  input  logic [N-1:0]     excl,
  output logic [N-1:0]     grant,
  output logic [OWN_W-1:0] idx,
  output logic             found
);

  logic [N-1:0] elig;
  int           cand;

  assign elig = req & ~excl;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && elig[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = OWN_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ra_2r1w_arb.sv
// Shares one 2-read/1-write register array among NREQ requesters: round-robin
// grants, combinational array drive, one-cycle read return with write forwarding.
module ra_2r1w_arb #(
  parameter int NREQ  = 4,
  parameter int ADR_W = 5,
  parameter int DAT_W = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ-1:0][ADR_W-1:0]  req_adr,
  input  logic [NREQ-1:0][DAT_W-1:0]  req_dat,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [NREQ-1:0][DAT_W-1:0]  rsp_dat,
  output logic                        strobe,
  output logic                        rd_enb_0,
  output logic [ADR_W-1:0]            rd_adr_0,
  output logic                        rd_enb_1,
  output logic [ADR_W-1:0]            rd_adr_1,
  output logic                        wr_enb_0,
  output logic [ADR_W-1:0]            wr_adr_0,
  output logic [DAT_W-1:0]            wr_dat_0,
  input  logic [DAT_W-1:0]            rd_dat_0,
  input  logic [DAT_W-1:0]            rd_dat_1
);
  import ra_arb_pkg::*;

  logic [OWN_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OWN_W-1:0] wr_ptr_reg, wr_ptr_next;
  ra_rsp_t          rsp_reg  [0:1];
  ra_rsp_t          rsp_next [0:1];
  logic [DAT_W-1:0] rd_dat_arr [0:1];

  logic [NREQ-1:0]  wr_mask, rd_mask;
  logic [NREQ-1:0]  wr_grant, a_grant, b_grant;
  logic [OWN_W-1:0] wr_idx, a_idx, b_idx;
  logic             wr_found, a_found, b_found;
  logic             fwd_0, fwd_1;

  assign rd_dat_arr[0] = rd_dat_0;
  assign rd_dat_arr[1] = rd_dat_1;

  // A requester whose response is being returned this cycle may not issue a new read.
  assign wr_mask = reset ? '0 : (req_valid & req_we);
  assign rd_mask = reset ? '0 : (req_valid & ~req_we & ~rsp_valid);

  ra_rr_pick #(.N(NREQ)) u_pick_wr (
    .req(wr_mask), .ptr(wr_ptr_reg), .excl('0),
    .grant(wr_grant), .idx(wr_idx), .found(wr_found)
  );

  ra_rr_pick #(.N(NREQ)) u_pick_rd_a (
    .req(rd_mask), .ptr(rd_ptr_reg), .excl('0),
    .grant(a_grant), .idx(a_idx), .found(a_found)
  );

  ra_rr_pick #(.N(NREQ)) u_pick_rd_b (
    .req(rd_mask), .ptr(idx_inc(a_idx, NREQ)), .excl(a_grant),
    .grant(b_grant), .idx(b_idx), .found(b_found)
  );

  assign req_ready = wr_grant | a_grant | b_grant;

  // One-hot grants select address/data; ungranted ports stay at zero.
  always_comb begin
    rd_adr_0 = '0;
    rd_adr_1 = '0;
    wr_adr_0 = '0;
    wr_dat_0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (a_grant[i])  rd_adr_0 = req_adr[i];
      if (b_grant[i])  rd_adr_1 = req_adr[i];
      if (wr_grant[i]) begin
        wr_adr_0 = req_adr[i];
        wr_dat_0 = req_dat[i];
      end
    end
  end

  assign rd_enb_0 = a_found;
  assign rd_enb_1 = b_found;
  assign wr_enb_0 = wr_found;
  assign strobe   = rd_enb_0 | rd_enb_1 | wr_enb_0;

  assign fwd_0 = a_found & wr_found & (rd_adr_0 == wr_adr_0);
  assign fwd_1 = b_found & wr_found & (rd_adr_1 == wr_adr_0);

  always_comb begin
    rsp_next[0] = '{valid: a_found, owner: a_idx, fwd: fwd_0,
                    fwd_dat: (fwd_0 ? wr_dat_0 : '0)};
    rsp_next[1] = '{valid: b_found, owner: b_idx, fwd: fwd_1,
                    fwd_dat: (fwd_1 ? wr_dat_0 : '0)};
  end

  always_comb begin
    wr_ptr_next = wr_found ? idx_inc(wr_idx, NREQ) : wr_ptr_reg;
    if (b_found)      rd_ptr_next = idx_inc(b_idx, NREQ);
    else if (a_found) rd_ptr_next = idx_inc(a_idx, NREQ);
    else              rd_ptr_next = rd_ptr_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      rsp_reg[0] <= '0;
      rsp_reg[1] <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      rsp_reg[0] <= rsp_next[0];
      rsp_reg[1] <= rsp_next[1];
    end
  end

  // Reset also suppresses a response already registered, so an in-flight read is dropped.
  always_comb begin
    rsp_valid = '0;
    rsp_dat   = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!reset && rsp_reg[p].valid && rsp_reg[p].owner == OWN_W'(i)) begin
          rsp_valid[i] = 1'b1;
          rsp_dat[i]   = rsp_reg[p].fwd ? rsp_reg[p].fwd_dat : rd_dat_arr[p];
        end
      end
    end
  end

endmodule

// File: doc/ra_2r1w_arb.md
# ra_2r1w_arb

Arbiter and sequencer that shares one `ra_2r1w_32x32_sdr` register array (2 read ports, 1 write port, 32 words × 32 bits) among NREQ requesters. Each cycle it grants up to two reads and one write using independent round-robin pointers, and drives the array's enables, addresses, write data and `strobe`. It returns read data to the owning requester one cycle later and forwards write data on a same-cycle read/write address collision. It sits directly in front of the array macro; requesters never touch the array ports.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `ADR_W`, 5: array address width (fixed by the macro).
- `DAT_W`, 32: array data width (fixed by the macro).

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NREQ: request pending, one bit per requester.
- `req_we`  in  NREQ: 1 = write, 0 = read.
- `req_adr`  in  NREQ×ADR_W: address per requester.
- `req_dat`  in  NREQ×DAT_W: write data per requester.
- `req_ready`  out  NREQ: grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NREQ: read data valid for requester i; one-cycle pulse.
- `rsp_dat`  out  NREQ×DAT_W: read data per requester.
- `strobe`, `rd_enb_0`, `rd_adr_0`, `rd_enb_1`, `rd_adr_1`, `wr_enb_0`, `wr_adr_0`, `wr_dat_0`  out: array controls, widths as the macro.
- `rd_dat_0`, `rd_dat_1`  in  DAT_W: array read data.

## Operation
- Array contract:
  - Read address and enable are sampled at edge N; `rd_dat_x` is valid during cycle N+1.
  - A write is committed at the edge where `wr_enb_0` = 1.
  - A same-edge read of the written address returns undefined data from the array.
- Write arbitration:
  - Among requesters with `req_valid & req_we`, grant the first at or after `wr_ptr`, searching ascending and wrapping.
  - On a grant, `wr_ptr` ← granted index + 1 (mod NREQ).
- Read arbitration:
  - Among requesters with `req_valid & ~req_we`, grant A is the first at or after `rd_ptr`. Grant B is the next one after A, with wrap.
  - A drives port 0; B drives port 1.
  - `rd_ptr` ← last granted index + 1 (mod NREQ). With no read grant, the pointer holds.
- `req_ready` is combinational from the current `req_valid`/`req_we` and the pointers. Requesters hold all request fields stable until granted.
- Array drive is combinational from the grants:
  - `rd_enb_x` = 1 only for a granted port.
  - Addresses and write data come from the granted requester. Ungranted ports drive address 0 and data 0.
  - `strobe` = OR of the three enables.
- Response path: registers per read port (valid, owner index, forward flag, forward data).
  - Cycle N+1: `rsp_valid[owner]` = 1.
  - `rsp_dat[owner]` = forward data if the forward flag is set, else `rd_dat_x`.
  - Non-owned `rsp_dat` = 0.
- Collision: when a granted read address equals the granted write address in the same cycle, set that port's forward flag and capture `wr_dat_0`. The response returns the new data.
- Read at N+1 of an address written at N: no forwarding; the array already holds the new value.
- A requester holds at most one outstanding read.
  - Its `req_ready` for a read is masked during the cycle its previous `rsp_valid` is high.
  - Back-to-back grants are therefore every other cycle per requester.

## Timing
- Reset values:
  - `rd_ptr` = `wr_ptr` = 0.
  - All response registers cleared.
  - `rsp_valid` = 0, `rsp_dat` = 0.
  - `strobe` and all enables = 0; `req_ready` = 0 during reset.
- Reset asserted with a response in flight: the response is dropped, with no `rsp_valid` in the following cycle.
- Latency: grant at N → `rsp_valid` at N+1. Write is visible to a read granted at N+1.
- Throughput: 2 reads + 1 write per cycle sustained across distinct requesters.
- Fairness: any continuously valid requester is granted within NREQ cycles (reads) or NREQ cycles (writes).

## Structure
- Package `ra_arb_pkg` holds:
  - constants `ADR_W`, `DAT_W`, `NREQ_MAX`;
  - typedef `ra_rsp_t` (valid, owner index, fwd flag, fwd data).
- Sub-module `ra_rr_pick`: inputs are the request mask, pointer and exclude mask. Outputs are a one-hot grant and an index.
  - Instantiated three times: write pick, read A, and read B with A excluded.

## Test plan
- Single write then read: req0 writes 0x0000AAAA to addr 1. Next cycle, req1 reads addr 1. Expect `rsp_valid[1]` one cycle later with 0x0000AAAA, and `strobe` high in both grant cycles.
- Dual read: reqs 0–3 all read addr 8 (preloaded with 0x8) with `rd_ptr` = 0.
  - Cycle 1 grants 0 and 1, and `rd_ptr` becomes 2.
  - Cycle 2 grants 2 and 3.
  - All four responses return 0x00000008.
- Collision forward: req2 writes 0xDEADBEEF to addr 5 while req0 reads addr 5 in the same cycle. Expect `rsp_dat[0]` = 0xDEADBEEF.
- Write round-robin: all four requesters write continuously. Expect grants in order 0, 1, 2, 3, 0, with exactly one `wr_enb_0` per cycle.
- Reset mid-flight: grant a read, then assert `reset` at the next edge. Expect no `rsp_valid`, both pointers at 0, and all outputs 0.
- Idle: no `req_valid`. Expect all enables, `strobe` and `req_ready` low, and pointers unchanged.
